top_hamming_codec: RTL and testbench



---
 rtl/top_hamming_codec.sv | 72 +++++++
 tb/tb_top_hamming_codec.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/top_hamming_codec.sv
// Hamming(7,4) encode -> error-inject -> single-error-correcting decode loopback.
// Two registered stages: encoded/corrupted word, then corrected outputs.
module top_hamming_codec (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_in,
  input  logic [6:0] error,
  output logic [3:0] d_out,
  output logic [6:0] codeword,
  output logic [2:0] syndrome,
  output logic       err_flag
);

  // Bit k of the result is Hamming position k+1; parity sits at positions 1, 2, 4.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  logic [6:0] enc_q, enc_d;
  logic [6:0] rx_q, rx_d;
  logic [3:0] dout_q, dout_d;
  logic [6:0] cw_q;
  logic [2:0] syn_q, syn_d;
  logic       flag_q, flag_d;
  logic [6:0] fixed;

  always_comb begin
    enc_d = encode(d_in);
    rx_d  = enc_d ^ error;
  end

  always_comb begin
    syn_d[0] = rx_q[0] ^ rx_q[2] ^ rx_q[4] ^ rx_q[6];
    syn_d[1] = rx_q[1] ^ rx_q[2] ^ rx_q[5] ^ rx_q[6];
    syn_d[2] = rx_q[3] ^ rx_q[4] ^ rx_q[5] ^ rx_q[6];
    fixed    = rx_q;
    // Non-zero syndrome names the 1-based position to flip; weight>=2 miscorrects by design.
    for (int unsigned k = 0; k < 7; k++) begin
      if (syn_d == 3'(k + 1)) fixed[k] = ~rx_q[k];
    end
    dout_d = {fixed[6], fixed[5], fixed[4], fixed[2]};
    flag_d = (syn_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q  <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      cw_q   <= '0;
      syn_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      enc_q  <= enc_d;
      rx_q   <= rx_d;
      dout_q <= dout_d;
      cw_q   <= enc_q;
      syn_q  <= syn_d;
      flag_q <= flag_d;
    end
  end

  assign d_out    = dout_q;
  assign codeword = cw_q;
  assign syndrome = syn_q;
  assign err_flag = flag_q;

endmodule

// File: tb/tb_top_hamming_codec.sv
// Directed + randomized checks of the Hamming(7,4) loopback pipeline against a
// position-based reference model (parity/syndrome computed from Hamming positions).
module tb_top_hamming_codec;

  logic       clk;
  logic       rst;
  logic [3:0] d_in;
  logic [6:0] error;
  logic [3:0] d_out;
  logic [6:0] codeword;
  logic [2:0] syndrome;
  logic       err_flag;

  int checks = 0;
  int errors = 0;

  // Reference pipeline: last sampled inputs and expected outputs.
  logic [3:0] m1_d;
  logic [6:0] m1_e;
  logic [3:0] exp_dout;
  logic [6:0] exp_cw;
  logic [2:0] exp_syn;
  logic       exp_flag;

  top_hamming_codec dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .error    (error),
    .d_out    (d_out),
    .codeword (codeword),
    .syndrome (syndrome),
    .err_flag (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data lives at Hamming positions 3,5,6,7; parity position 2^k covers every
  // position whose index has bit k set.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    int dpos[4] = '{3, 5, 6, 7};
    logic [6:0] cw;
    cw = '0;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
    for (int k = 0; k < 3; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ cw[p-1];
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  function automatic logic [2:0] ref_syndrome(input logic [6:0] rx);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (rx[p-1]) s = s ^ p;
    return 3'(s);
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] rx);
    int dpos[4] = '{3, 5, 6, 7};
    logic [6:0] fx;
    logic [2:0] s;
    logic [3:0] d;
    fx = rx;
    s  = ref_syndrome(rx);
    if (s != 0) fx[int'(s)-1] = ~fx[int'(s)-1];
    for (int i = 0; i < 4; i++) d[i] = fx[dpos[i]-1];
    return d;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic [3:0] d, input logic [6:0] e, input logic r);
    logic [6:0] rx;
    d_in  = d;
    error = e;
    rst   = r;
    @(posedge clk);
    if (r) begin
      exp_dout = '0; exp_cw = '0; exp_syn = '0; exp_flag = 1'b0;
      m1_d = '0; m1_e = '0;
    end else begin
      rx       = ref_encode(m1_d) ^ m1_e;
      exp_cw   = ref_encode(m1_d);
      exp_syn  = ref_syndrome(rx);
      exp_flag = (exp_syn != 0);
      exp_dout = ref_decode(rx);
      m1_d = d; m1_e = e;
    end
    #1;
    check("d_out",    8'(d_out),    8'(exp_dout));
    check("codeword", 8'(codeword), 8'(exp_cw));
    check("syndrome", 8'(syndrome), 8'(exp_syn));
    check("err_flag", 8'(err_flag), 8'(exp_flag));
  endtask

  initial begin
    logic [3:0] prev_d;
    logic [2:0] prev_syn;
    logic [3:0] rd;
    logic [6:0] re;

    // Reset with undriven inputs, then with a noisy pattern held for two edges.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_x_d_out", 8'(d_out), 8'h00);
    check("rst_x_cw", 8'(codeword), 8'h00);
    step(4'b1011, 7'h7F, 1'b1);
    step(4'b1011, 7'h7F, 1'b1);
    check("rst_d_out", 8'(d_out), 8'h00);
    check("rst_codeword", 8'(codeword), 8'h00);
    check("rst_syndrome", 8'(syndrome), 8'h00);
    check("rst_err_flag", 8'(err_flag), 8'h00);

    // Directed clean/error vectors; each result appears one step after it is driven.
    step(4'b1011, 7'b0000000, 1'b0);
    step(4'b1111, 7'b0000000, 1'b0);
    check("clean_cw_1011", 8'(codeword), 8'b01010101);
    check("clean_dout_1011", 8'(d_out), 8'h0B);
    check("clean_syn_1011", 8'(syndrome), 8'h00);
    check("clean_flag_1011", 8'(err_flag), 8'h00);
    step(4'b0000, 7'b0000000, 1'b0);
    check("clean_cw_1111", 8'(codeword), 8'h7F);
    step(4'b1011, 7'b0000100, 1'b0);
    check("clean_cw_0000", 8'(codeword), 8'h00);
    step(4'b0000, 7'b0000011, 1'b0);
    check("single_syn", 8'(syndrome), 8'h03);
    check("single_flag", 8'(err_flag), 8'h01);
    check("single_dout", 8'(d_out), 8'h0B);
    step(4'b0101, 7'b0000000, 1'b0);
    check("double_syn", 8'(syndrome), 8'h03);
    check("double_flag", 8'(err_flag), 8'h01);
    check("double_dout", 8'(d_out), 8'h01);

    // Back-to-back sweep: 16 data values x {no error, each single-bit error}.
    step(4'h0, 7'h00, 1'b0);
    prev_d = 'x;
    prev_syn = 'x;
    for (int d = 0; d < 16; d++) begin
      for (int k = -1; k < 7; k++) begin
        logic [6:0] m;
        m = (k < 0) ? 7'h00 : 7'(1 << k);
        step(4'(d), m, 1'b0);
        if (!$isunknown(prev_d)) begin
          check("sweep_dout", 8'(d_out), 8'(prev_d));
          check("sweep_syn", 8'(syndrome), 8'(prev_syn));
        end
        prev_d = 4'(d);
        prev_syn = (k < 0) ? 3'd0 : 3'(k + 1);
      end
    end
    step(4'h0, 7'h00, 1'b0);
    check("sweep_last_dout", 8'(d_out), 8'(prev_d));
    check("sweep_last_syn", 8'(syndrome), 8'(prev_syn));

    // Random stream with arbitrary error weights and occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(15)), 7'($urandom_range(127)), ($urandom_range(39) == 0));
    end

    // Mid-stream reset: flush, then first post-reset sample emerges two edges later.
    for (int i = 0; i < 5; i++) step(4'($urandom_range(15)), 7'h00, 1'b0);
    step(4'($urandom_range(15)), 7'($urandom_range(127)), 1'b1);
    check("midrst_dout", 8'(d_out), 8'h00);
    check("midrst_cw", 8'(codeword), 8'h00);
    rd = 4'($urandom_range(15));
    re = 7'(1 << $urandom_range(6));
    step(rd, re, 1'b0);
    check("midrst_flushed", 8'(d_out), 8'h00);
    step(4'($urandom_range(15)), 7'h00, 1'b0);
    check("midrst_first_dout", 8'(d_out), 8'(rd));
    check("midrst_first_cw", 8'(codeword), 8'(ref_encode(rd)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
